// File: rtl/tru_16bit_tuantu.sv
// ---------------------------------------------------------------------------
// tru_16bit_tuantu
//
// Sequential multi-nibble subtractor. It computes D = A - B - bin on
// 4*NIBBLES-bit unsigned operands. It processes one 4-bit nibble per clock,
// starting with the least significant nibble, through a 4-bit borrow-chain
// slice. The borrow is registered between nibbles.
//
// Handshake (start/done):
//   start is a request. It is accepted only at a clock edge while the block
//   is idle (busy=0). A, B and bin are captured at that same edge and may
//   change freely afterwards. A start seen while busy=1 is dropped; there is
//   no queueing. done is a single-cycle pulse, raised together with the new
//   D/bo. busy covers the whole operation, including the done cycle, so a
//   start held high is accepted on the edge after done falls.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      operation request, sampled only while idle
//   A, B       minuend / subtrahend (W bits), captured with start
//   bin        borrow into nibble 0, captured with start
//   busy       high while an operation is in flight (CALC and DONE)
//   done       one-cycle completion pulse
//   D          registered difference; holds the last result
//   bo         registered borrow-out of the top nibble; holds the last result
//   state_dbg  current FSM state (0=IDLE, 1=CALC, 2=DONE), for observation
// ---------------------------------------------------------------------------
module tru_16bit_tuantu #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] D,
    output logic         bo,
    output logic [1:0]   state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // A 1-bit counter is kept for NIBBLES=1 so the vector is never zero width.
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic [W-1:0]   res_r;
    logic           brw;

    logic [3:0]     nib_a;
    logic [3:0]     nib_b;
    logic [3:0]     nib_d;
    logic           nib_bo;
    logic [4:0]     slice_out;
    logic [W-1:0]   res_nxt;
    logic           last_nib;

    // 4-bit borrow-chain slice: {borrow, diff} = x - y - bi.
    // Bit 4 of the 5-bit result is set exactly when the true difference is
    // negative, which is the borrow-out.
    function automatic logic [4:0] sub4(input logic [3:0] x,
                                        input logic [3:0] y,
                                        input logic       bi);
        logic [4:0] t;
        t = {1'b0, x} - {1'b0, y} - {4'b0000, bi};
        return t;
    endfunction

    // Nibble selection and the slice itself.
    always_comb begin
        nib_a     = a_r[int'(cnt) * 4 +: 4];
        nib_b     = b_r[int'(cnt) * 4 +: 4];
        slice_out = sub4(nib_a, nib_b, brw);
        nib_d     = slice_out[3:0];
        nib_bo    = slice_out[4];
        last_nib  = (cnt == LAST);
    end

    // Working result with the current nibble merged in; at the last nibble
    // this is the full difference that gets published to D.
    always_comb begin
        res_nxt                       = res_r;
        res_nxt[int'(cnt) * 4 +: 4]   = nib_d;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last_nib) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            res_r <= '0;
            brw   <= 1'b0;
            D     <= '0;
            bo    <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r <= A;
                        b_r <= B;
                        // Seeding brw with bin makes nibble 0 use bin as its
                        // borrow-in without a separate mux on cnt.
                        brw <= bin;
                        cnt <= '0;
                    end
                end
                CALC: begin
                    res_r <= res_nxt;
                    brw   <= nib_bo;
                    if (last_nib) begin
                        cnt  <= '0;
                        D    <= res_nxt;
                        bo   <= nib_bo;
                        done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_tru_16bit_tuantu.sv
module tb_tru_16bit_tuantu;

    logic        clk;
    logic        rst_n;

    // Default-width instance (NIBBLES=4)
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        busy;
    logic        done;
    logic [15:0] d;
    logic        bo;
    logic [1:0]  state_dbg;

    // Single-nibble instance (NIBBLES=1)
    logic        start1;
    logic [3:0]  a1;
    logic [3:0]  b1;
    logic        bin1;
    logic        busy1;
    logic        done1;
    logic [3:0]  d1;
    logic        bo1;
    logic [1:0]  state_dbg1;

    int          n_tests;
    int          n_fail;
    logic [15:0] last_d;
    logic [16:0] exp_q[$];

    tru_16bit_tuantu #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .A         (a),
        .B         (b),
        .bin       (bin),
        .busy      (busy),
        .done      (done),
        .D         (d),
        .bo        (bo),
        .state_dbg (state_dbg)
    );

    tru_16bit_tuantu #(.NIBBLES(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start1),
        .A         (a1),
        .B         (b1),
        .bin       (bin1),
        .busy      (busy1),
        .done      (done1),
        .D         (d1),
        .bo        (bo1),
        .state_dbg (state_dbg1)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // One operation on the 16-bit instance with hand-computed expectations.
    task automatic run4(input logic [15:0] av, input logic [15:0] bv, input logic bi,
                        input logic [15:0] ed, input logic eb, input string tag);
        logic [16:0] e;
        int          cyc;
        exp_q.push_back({eb, ed});
        @(negedge clk);
        start = 1'b1; a = av; b = bv; bin = bi;
        @(negedge clk);
        // Scramble inputs after the start edge: only latched values may count.
        start = 1'b0; a = ~av; b = ~bv; bin = ~bi;
        check({tag, "_busy"}, busy, 1);
        cyc = 0;
        while (!done && cyc < 20) begin
            check({tag, "_hold"}, d, last_d);
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_lat"}, cyc, 4);
        e = exp_q.pop_front();
        check({tag, "_d"}, d, e[15:0]);
        check({tag, "_bo"}, bo, e[16]);
        last_d = ed;
        @(negedge clk);
        check({tag, "_done_fall"}, done, 0);
        check({tag, "_busy_fall"}, busy, 0);
    endtask

    // One operation on the single-nibble instance, expectation from a model.
    task automatic run1(input logic [3:0] av, input logic [3:0] bv, input logic bi);
        int diff;
        int cyc;
        diff = int'(av) - int'(bv) - int'(bi);
        @(negedge clk);
        start1 = 1'b1; a1 = av; b1 = bv; bin1 = bi;
        @(negedge clk);
        start1 = 1'b0; a1 = ~av; b1 = ~bv; bin1 = ~bi;
        cyc = 0;
        while (!done1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        if (!done1 || cyc != 1 || d1 !== 4'(diff & 15) || bo1 !== (diff < 0)) begin
            check($sformatf("n1_%0h_%0h_%0d_done", av, bv, bi), done1, 1);
            check($sformatf("n1_%0h_%0h_%0d_lat", av, bv, bi), cyc, 1);
            check($sformatf("n1_%0h_%0h_%0d_d", av, bv, bi), d1, 32'(diff & 15));
            check($sformatf("n1_%0h_%0h_%0d_bo", av, bv, bi), bo1, (diff < 0) ? 1 : 0);
        end else begin
            n_tests++;
        end
        @(negedge clk);
        check("n1_done_fall", done1, 0);
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        logic [15:0] d_at_done;
        logic        bo_at_done;

        n_tests = 0;
        n_fail  = 0;
        last_d  = 16'h0000;
        rst_n   = 1'b1;
        start   = 1'b0; a  = '0; b  = '0; bin  = 1'b0;
        start1  = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;

        // Reset asserted mid-cycle: outputs clear without a clock edge.
        #3 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_d", d, 16'h0000);
        check("rst_bo", bo, 0);
        check("rst_state", state_dbg, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle for 10 cycles with start low.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_outs", {busy, done, bo, d}, 0);
        end

        // Basic results
        run4(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, "basic_1234");
        run4(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, "zero_bin");
        run4(16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0, "ffff_m1");
        // Borrow ripple through every nibble
        run4(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, "ripple");

        // Start while busy: second request must be dropped.
        @(negedge clk);
        start = 1'b1; a = 16'h0005; b = 16'h0003; bin = 1'b0;
        @(negedge clk);
        busy_cnt = 0; done_cnt = 0; d_at_done = 16'hDEAD; bo_at_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                d_at_done  = d;
                bo_at_done = bo;
            end
            if (i == 1) begin
                start = 1'b1; a = 16'h0001; b = 16'h0002;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("sbusy_busy_cycles", busy_cnt, 5);
        check("sbusy_done_pulses", done_cnt, 1);
        check("sbusy_d", d_at_done, 16'h0002);
        check("sbusy_bo", bo_at_done, 0);
        last_d = 16'h0002;

        // Reset mid-operation, after nibble 1 has been processed.
        start = 1'b1; a = 16'h8000; b = 16'h0001; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_d", d, 16'h0000);
        check("abort_bo", bo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        last_d = 16'h0000;
        run4(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, "after_abort");

        // NIBBLES=1: hand-computed corner, then all 512 combinations.
        @(negedge clk);
        start1 = 1'b1; a1 = 4'h1; b1 = 4'h1; bin1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("n1_busy", busy1, 1);
        @(negedge clk);
        check("n1_corner_done", done1, 1);
        check("n1_corner_d", d1, 4'hF);
        check("n1_corner_bo", bo1, 1);
        @(negedge clk);
        check("n1_corner_fall", {busy1, done1}, 0);

        for (int ai = 0; ai < 16; ai++)
            for (int bi = 0; bi < 16; bi++)
                for (int ci = 0; ci < 2; ci++)
                    run1(4'(ai), 4'(bi), ci[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tru_16bit_tuantu.md
# tru_16bit_tuantu

Sequential multi-nibble subtractor. It computes D = A − B − bin on NIBBLES×4-bit unsigned operands, one 4-bit nibble per clock, LSB nibble first, through a 4-bit borrow-chain slice with the same arithmetic as the team's 4-bit subtractor. The borrow is registered between nibbles. The block is the control and datapath stage directly upstream of that 4-bit slice: it slices the operands, feeds nibbles and the borrow to the slice, and collects its D/bo results into a wide word. A start/done handshake connects it to the surrounding datapath.

## Interface
- NIBBLES, default 4, number of 4-bit nibbles; operand width W = 4*NIBBLES; legal range 1..8
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- A  input  W  minuend, unsigned; sampled with start
- B  input  W  subtrahend, unsigned; sampled with start
- bin  input  1  borrow-in to nibble 0; sampled with start
- busy  output  1  high in CALC and DONE
- done  output  1  one-cycle completion pulse
- D  output  W  difference, registered; holds the last result
- bo  output  1  borrow-out of the top nibble, registered; holds the last result

## Operation
- States: IDLE, CALC, DONE. A nibble counter cnt runs 0..NIBBLES−1.
- IDLE:
  - When start=1 at a clock edge, latch A, B and bin into working registers, clear cnt, and go to CALC.
  - When start=0, stay in IDLE.
- CALC, each edge:
  - Compute {b, d} = A[cnt] − B[cnt] − brw as a 4-bit difference with 1-bit borrow. brw is bin for cnt=0 and the registered borrow otherwise.
  - Store d into nibble cnt of the working result, set brw <= b, and increment cnt.
  - At the edge where cnt = NIBBLES−1: copy the full working result to D and the final borrow to bo, set done <= 1, and go to DONE.
- DONE: on the next edge, clear done and busy, and go to IDLE.
- Arithmetic:
  - D = (A − B − bin) mod 2^W.
  - bo = 1 if and only if A < B + bin, with the comparison in W+1 bits.
- D and bo change only at the completion edge. They keep the previous result throughout CALC.
- start is ignored in CALC and DONE. No queueing: a start pulse received while busy is lost.
- A, B and bin may change freely after the start edge. The operation uses only the latched values.

## Timing
- Reset (rst_n=0, asynchronous):
  - state = IDLE, busy = 0, done = 0, D = 0, bo = 0, cnt = 0, brw = 0.
  - Reset takes effect immediately and does not wait for a clock edge.
- Reset during CALC or DONE aborts the operation. No done pulse is produced, and D and bo read 0 after reset.
- Deassertion of rst_n: the first edge with rst_n=1 may accept start.
- Edge numbering: start is sampled at edge t0.
  - busy=1 after t0.
  - Nibble k is processed at edge t(k+1).
  - done=1 and the new D and bo appear after edge tNIBBLES.
  - done=0 and busy=0 after edge tNIBBLES+1.
- Latency from the start edge to done visible is NIBBLES cycles (4 at default). Throughput is one operation per NIBBLES+2 cycles.
- Back-to-back: start held high continuously is accepted on the first edge in IDLE, which is the edge after done drops.
- NIBBLES=1: CALC lasts one edge. The done pulse still lasts exactly one cycle.

## Test plan
- Reset then idle: rst_n=0 asserted mid-cycle -> busy=0, done=0, D=0x0000, bo=0 immediately, without a clock edge. With start=0 for 10 cycles, all outputs stay unchanged.
- Basic results, default NIBBLES=4:
  - A=0x1234, B=0x0234, bin=0 -> done exactly 4 cycles after the start edge, D=0x1000, bo=0.
  - A=0x0000, B=0x0000, bin=1 -> D=0xFFFF, bo=1.
  - A=0xFFFF, B=0x0001, bin=0 -> D=0xFFFE, bo=0.
- Borrow ripple across all nibbles: A=0x0000, B=0x0001, bin=0 -> D=0xFFFF, bo=1. D holds its previous value in every cycle of CALC.
- Start while busy: issue start with A=0x0005, B=0x0003; one cycle later issue start with A=0x0001, B=0x0002 -> only one done pulse, D=0x0002, bo=0. busy stays high for 5 cycles.
- Reset mid-operation: drop rst_n after nibble 1 of A=0x8000, B=0x0001 -> no done pulse, D=0, bo=0. A fresh start after release returns D=0x7FFF, bo=0.
- Exhaustive at NIBBLES=1: all 512 combinations of (A, B, bin) match (A−B−bin) mod 16 and the bo rule. Cases include A=1, B=1, bin=1 -> D=0xF, bo=1.
